// File: rtl/dsp_16x16_fix14_16_signed_mul.sv
// Registered signed Q1.14 multiplier and dual-lane add/sub primitive.
// Both map onto a single SB_MAC16-style DSP tile with a 1-cycle output register.
module dsp_16x16_fix14_16_signed_mul #(
  parameter bit SATURATE = 1'b1
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        dsp_CE,
  input  logic [15:0] dsp_A,
  input  logic [15:0] dsp_B,
  output logic [15:0] fix_14_16_Out
);

  logic signed [31:0] prod;
  logic signed [31:0] shifted;
  logic        [15:0] sat_val;
  logic        [15:0] wrap_val;
  logic        [15:0] next_out;

  assign prod     = $signed(dsp_A) * $signed(dsp_B);
  // Arithmetic shift truncates toward -inf; no rounding term is added.
  assign shifted  = prod >>> 14;
  assign wrap_val = shifted[15:0];

  always_comb begin
    sat_val = wrap_val;
    if (shifted > 32'sd32767)
      sat_val = 16'h7FFF;
    else if (shifted < -32'sd32768)
      sat_val = 16'h8000;
  end

  assign next_out = SATURATE ? sat_val : wrap_val;

  always_ff @(posedge sys_clk) begin
    if (sys_rst)
      fix_14_16_Out <= 16'h0000;
    else if (dsp_CE)
      fix_14_16_Out <= next_out;
  end

endmodule

module dsp_16x16_fix14_16_signed_adder #(
  parameter bit SATURATE = 1'b0,
  parameter bit TOP_SUB  = 1'b0,
  parameter bit BOT_SUB  = 1'b1
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        dsp_CE,
  input  logic [15:0] dsp_A,
  input  logic [15:0] dsp_B,
  input  logic [15:0] dsp_C,
  input  logic [15:0] dsp_D,
  output logic [31:0] dsp_o
);

  logic [16:0] top_sum;
  logic [16:0] bot_sum;
  logic [15:0] top_val;
  logic [15:0] bot_val;

  assign top_sum = TOP_SUB ? ({dsp_C[15], dsp_C} - {dsp_A[15], dsp_A})
                           : ({dsp_C[15], dsp_C} + {dsp_A[15], dsp_A});
  assign bot_sum = BOT_SUB ? ({dsp_D[15], dsp_D} - {dsp_B[15], dsp_B})
                           : ({dsp_D[15], dsp_D} + {dsp_B[15], dsp_B});

  // A 17-bit lane overflowed 16 bits when its top two bits disagree.
  always_comb begin
    top_val = top_sum[15:0];
    bot_val = bot_sum[15:0];
    if (SATURATE) begin
      if (top_sum[16] != top_sum[15])
        top_val = top_sum[16] ? 16'h8000 : 16'h7FFF;
      if (bot_sum[16] != bot_sum[15])
        bot_val = bot_sum[16] ? 16'h8000 : 16'h7FFF;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst)
      dsp_o <= 32'h0000_0000;
    else if (dsp_CE)
      dsp_o <= {top_val, bot_val};
  end

endmodule

// File: tb/tb_dsp_16x16_fix14_16_signed_mul.sv
// Directed bench for the Q1.14 multiplier and add/sub primitive.
// Expected values are hand-computed constants.
module tb_dsp_16x16_fix14_16_signed_mul;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic [15:0] ma, mb;
  logic [15:0] m_sat, m_wrap;
  logic [15:0] aa, ab, ac, ad;
  logic [31:0] add_o;
  logic [15:0] fb, fc, fd;
  logic [31:0] fb_o;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  dsp_16x16_fix14_16_signed_mul #(.SATURATE(1'b1)) u_sat (
    .sys_clk(clk), .sys_rst(rst), .dsp_CE(ce),
    .dsp_A(ma), .dsp_B(mb), .fix_14_16_Out(m_sat)
  );

  dsp_16x16_fix14_16_signed_mul #(.SATURATE(1'b0)) u_wrap (
    .sys_clk(clk), .sys_rst(rst), .dsp_CE(ce),
    .dsp_A(ma), .dsp_B(mb), .fix_14_16_Out(m_wrap)
  );

  dsp_16x16_fix14_16_signed_adder u_add (
    .sys_clk(clk), .sys_rst(rst), .dsp_CE(ce),
    .dsp_A(aa), .dsp_B(ab), .dsp_C(ac), .dsp_D(ad),
    .dsp_o(add_o)
  );

  dsp_16x16_fix14_16_signed_adder u_fb (
    .sys_clk(clk), .sys_rst(rst), .dsp_CE(ce),
    .dsp_A(fb_o[15:0]), .dsp_B(fb), .dsp_C(fc), .dsp_D(fd),
    .dsp_o(fb_o)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h want %08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; ce = 1'b1;
    ma = 16'h1234; mb = 16'h4321;
    aa = 16'h1111; ab = 16'h2222;
    ac = 16'h3333; ad = 16'h4444;
    fb = 16'h0002; fc = 16'h0010; fd = 16'h0005;
    tick();
    chk("rst_sat", {16'h0, m_sat}, 32'h0);
    chk("rst_wrap", {16'h0, m_wrap}, 32'h0);
    chk("rst_add", add_o, 32'h0);
    chk("rst_fb", fb_o, 32'h0);

    @(negedge clk);
    rst = 1'b0;
    ma = 16'h4000; mb = 16'h2000;
    aa = 16'h0234; ab = 16'h0040;
    ac = 16'h1000; ad = 16'h0100;
    tick();
    chk("mul_1x0.5", {16'h0, m_sat}, 32'h2000);
    chk("add_dflt", add_o, 32'h1234_00C0);
    chk("fb_cyc1", fb_o, 32'h0010_0003);

    @(negedge clk);
    ma = 16'hC000; mb = 16'h4000;
    ad = 16'h8000; ab = 16'h0001;
    tick();
    chk("mul_neg1", {16'h0, m_sat}, 32'h0000_C000);
    chk("add_wrap", {16'h0, add_o[15:0]}, 32'h0000_7FFF);
    chk("fb_cyc2", fb_o, 32'h0013_0003);

    @(negedge clk);
    ma = 16'h0001; mb = 16'h0001;
    tick();
    chk("mul_tiny", {16'h0, m_sat}, 32'h0);

    @(negedge clk);
    ma = 16'hFFFF; mb = 16'h0001;
    tick();
    chk("mul_floor", {16'h0, m_sat}, 32'h0000_FFFF);

    @(negedge clk);
    ma = 16'h8000; mb = 16'h8000;
    tick();
    chk("sat_pos", {16'h0, m_sat}, 32'h0000_7FFF);
    chk("wrap_pos", {16'h0, m_wrap}, 32'h0);

    @(negedge clk);
    ma = 16'h7FFF; mb = 16'h8000;
    tick();
    chk("sat_neg", {16'h0, m_sat}, 32'h0000_8000);
    chk("wrap_neg", {16'h0, m_wrap}, 32'h0000_0002);

    @(negedge clk);
    ce = 1'b0;
    ma = 16'h4000; mb = 16'h4000;
    ad = 16'h0000; ab = 16'h0000;
    tick();
    chk("hold_mul", {16'h0, m_sat}, 32'h0000_8000);
    chk("hold_add", add_o, 32'h1234_7FFF);

    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("rst_noce_mul", {16'h0, m_sat}, 32'h0);
    chk("rst_noce_add", add_o, 32'h0);

    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("post_rst_idle", {16'h0, m_sat}, 32'h0);

    @(negedge clk);
    ce = 1'b1;
    tick();
    chk("resume_mul", {16'h0, m_sat}, 32'h0000_4000);
    chk("resume_add", add_o, 32'h1234_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
